// File: rtl/pwm_capture.sv
// PWM burst analyser: measures period and high time of each cycle in i_clk units,
// and reports the pulse count once the line has been quiet for i_timeout clocks.
module pwm_capture #(
  parameter int CW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_pwm,
  input  logic [CW-1:0] i_timeout,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_high,
  output logic          o_valid,
  output logic          o_sat,
  output logic [15:0]   o_times,
  output logic          o_done,
  output logic          o_busy
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state;
  logic          s_meta;
  logic          s_pwm;
  logic          s_d;
  logic          rise;
  logic          fall;
  logic [CW-1:0] r_pcnt;
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_hold;
  logic [15:0]   r_tcnt;

  // The whole chain resets high so a line already high at reset never looks like a rise;
  // a low line only produces a fall, which is harmless while idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s_meta <= 1'b1;
      s_pwm  <= 1'b1;
      s_d    <= 1'b1;
    end else begin
      s_meta <= i_pwm;
      s_pwm  <= s_meta;
      s_d    <= s_pwm;
    end
  end

  assign rise   = s_pwm & ~s_d;
  assign fall   = ~s_pwm & s_d;
  assign o_busy = (state == MEAS);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      r_pcnt   <= '0;
      r_hcnt   <= '0;
      r_hold   <= '0;
      r_tcnt   <= '0;
      o_period <= '0;
      o_high   <= '0;
      o_valid  <= 1'b0;
      o_sat    <= 1'b0;
      o_times  <= '0;
      o_done   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      if (!i_en) begin
        state  <= IDLE;
        r_pcnt <= '0;
        r_hcnt <= '0;
        r_hold <= '0;
        r_tcnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state  <= MEAS;
              r_pcnt <= CNT_ONE;
              r_hcnt <= CNT_ONE;
              r_hold <= '0;
              r_tcnt <= 16'd1;
            end
          end
          MEAS: begin
            // A rise closes the running period, so it takes priority over a coincident timeout.
            if (rise) begin
              o_period <= r_pcnt;
              o_high   <= r_hold;
              o_sat    <= (r_pcnt == CNT_MAX) || (r_hold == CNT_MAX);
              o_valid  <= 1'b1;
              r_pcnt   <= CNT_ONE;
              r_hcnt   <= CNT_ONE;
              if (r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
            end else if ((i_timeout != '0) && (r_pcnt == i_timeout)) begin
              o_times <= r_tcnt;
              o_done  <= 1'b1;
              state   <= IDLE;
            end else begin
              if (r_pcnt != CNT_MAX) r_pcnt <= r_pcnt + CNT_ONE;
              if (s_pwm && (r_hcnt != CNT_MAX)) r_hcnt <= r_hcnt + CNT_ONE;
              if (fall) r_hold <= r_hcnt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected strobes are queued as pulses are driven
// and matched (value and cycle) when the DUT produces them.
module tb_pwm_capture;

  typedef struct {
    bit          is_done;
    logic [31:0] a;
    logic [31:0] b;
    bit          sat;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        pwm;
  logic [31:0] timeout;
  logic [31:0] period;
  logic [31:0] high;
  logic        valid;
  logic        sat;
  logic [15:0] times;
  logic        done;
  logic        busy;

  logic        en8;
  logic        pwm8;
  logic [7:0]  timeout8;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        sat8;
  logic [15:0] times8;
  logic        done8;
  logic        busy8;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_c = 0;
  exp_t sb[$];
  exp_t e;

  pwm_capture #(.CW(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pwm(pwm), .i_timeout(timeout),
    .o_period(period), .o_high(high), .o_valid(valid), .o_sat(sat),
    .o_times(times), .o_done(done), .o_busy(busy)
  );

  pwm_capture #(.CW(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en8), .i_pwm(pwm8), .i_timeout(timeout8),
    .o_period(period8), .o_high(high8), .o_valid(valid8), .o_sat(sat8),
    .o_times(times8), .o_done(done8), .o_busy(busy8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pulse; when it closes a previous period, queue the o_valid it must produce.
  task automatic send_pulse(input int per, input int hi, input bit closes);
    if (closes) sb.push_back('{1'b0, 32'(per), 32'(hi), 1'b0, cyc + 3});
    last_c = cyc;
    pwm = 1'b1;
    repeat (hi) tick();
    pwm = 1'b0;
    repeat (per - hi) tick();
  endtask

  task automatic expect_done(input int n, input int tmo);
    sb.push_back('{1'b1, 32'(n), 32'd0, 1'b0, last_c + 3 + tmo});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_output("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1 || done === 1'b1) begin
      check_output("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output("strobe_kind", 32'(done), 32'(e.is_done));
        check_output("strobe_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_done) begin
          check_output("o_times", 32'(times), e.a);
          check_output("busy_at_done", 32'(busy), 32'd0);
        end else begin
          check_output("o_period", period, e.a);
          check_output("o_high", high, e.b);
          check_output("o_sat", 32'(sat), 32'(e.sat));
        end
      end
    end
  end

  initial begin
    int n;
    int c;
    rst_n = 1'b0; en = 1'b0; pwm = 1'b0; timeout = '0;
    en8 = 1'b0; pwm8 = 1'b0; timeout8 = '0;
    repeat (3) tick();
    check_output("rst_period", period, 32'd0);
    check_output("rst_high", high, 32'd0);
    check_output("rst_flags", 32'({valid, sat, done, busy}), 32'd0);
    check_output("rst_times", 32'(times), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] T1 period 10 high 4, 3 pulses, timeout 50");
    en = 1'b1; timeout = 32'd50;
    send_pulse(10, 4, 1'b0);
    check_output("t1_busy", 32'(busy), 32'd1);
    send_pulse(10, 4, 1'b1);
    send_pulse(10, 4, 1'b1);
    expect_done(3, 50);
    drain(200);

    $display("[TB] T2 period 200 high 1, 5 pulses, timeout 300");
    timeout = 32'd300;
    send_pulse(200, 1, 1'b0);
    for (int i = 0; i < 4; i++) send_pulse(200, 1, 1'b1);
    expect_done(5, 300);
    drain(600);

    $display("[TB] T3 enable dropped mid-burst");
    timeout = 32'd50;
    send_pulse(10, 4, 1'b0);
    send_pulse(10, 4, 1'b1);
    en = 1'b0;
    tick();
    check_output("t3_busy_off", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) send_pulse(10, 4, 1'b0);
    repeat (80) tick();
    check_output("t3_times_kept", 32'(times), 32'd5);
    check_output("t3_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] T5 line high through reset and enable");
    pwm = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    repeat (20) tick();
    check_output("t5_busy", 32'(busy), 32'd0);
    check_output("t5_period", period, 32'd0);
    pwm = 1'b0;
    repeat (5) tick();
    send_pulse(10, 3, 1'b0);
    send_pulse(10, 3, 1'b1);
    expect_done(2, 50);
    drain(200);

    $display("[TB] T6 reset mid-burst");
    send_pulse(10, 4, 1'b0);
    send_pulse(10, 4, 1'b1);
    sb.push_back('{1'b0, 32'd10, 32'd4, 1'b0, cyc + 3});
    pwm = 1'b1;
    repeat (4) tick();
    pwm = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_output("t6_period", period, 32'd0);
    check_output("t6_high", high, 32'd0);
    check_output("t6_times", 32'(times), 32'd0);
    check_output("t6_flags", 32'({valid, sat, done, busy}), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check_output("t6_sb_empty", 32'(sb.size()), 32'd0);
    send_pulse(10, 4, 1'b0);
    send_pulse(10, 4, 1'b1);
    send_pulse(10, 4, 1'b1);
    expect_done(3, 50);
    drain(200);

    $display("[TB] T4 CW=8, period 300, timeout disabled");
    en8 = 1'b1;
    pwm8 = 1'b1;
    repeat (4) tick();
    pwm8 = 1'b0;
    repeat (296) tick();
    c = cyc;
    pwm8 = 1'b1;
    n = 0;
    while (valid8 !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (n == 4) pwm8 = 1'b0;
    end
    check_output("t4_valid_cycle", 32'(cyc), 32'(c + 3));
    check_output("t4_period", 32'(period8), 32'd255);
    check_output("t4_high", 32'(high8), 32'd4);
    check_output("t4_sat", 32'(sat8), 32'd1);
    check_output("t4_no_done", 32'(done8), 32'd0);
    pwm8 = 1'b0;
    repeat (5) tick();

    check_output("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
